// File: rtl/seq_mult_8bit.sv
// Sequential 8x8 unsigned shift-and-add multiplier and the 8-bit ripple-carry adder it drives.
// The adder sits in this file so the multiplier builds on its own; the single FADDER_8bit
// instance is the only datapath adder.

// 8-bit ripple-carry adder: {cout_o, sum_o} = x_i + y_i + cin_i.
module FADDER_8bit (
  input  logic [7:0] x_i,
  input  logic [7:0] y_i,
  input  logic       cin_i,
  output logic [7:0] sum_o,
  output logic       cout_o
);

  logic [8:0] carry;

  assign carry[0] = cin_i;

  // One full adder per bit, carry rippling from bit 0 upwards.
  for (genvar i = 0; i < 8; i++) begin : g_bit
    assign sum_o[i]   = x_i[i] ^ y_i[i] ^ carry[i];
    assign carry[i+1] = (x_i[i] & y_i[i]) | (x_i[i] & carry[i]) | (y_i[i] & carry[i]);
  end

  assign cout_o = carry[8];

endmodule

// Shift-and-add multiplier: one iteration per clock, 8 iterations per product.
module seq_mult_8bit (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [7:0]  a_i,
  input  logic [7:0]  b_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [15:0] product_o
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e      state_q;
  logic [7:0]  m_q;
  logic [7:0]  q_q;
  logic [7:0]  acc_q;
  logic [2:0]  cnt_q;
  logic        busy_q;
  logic        done_q;
  logic [15:0] product_q;

  logic [7:0]  add_sum;
  logic        add_cout;
  logic        c_d;
  logic [7:0]  acc_sum_d;
  logic [7:0]  acc_d;
  logic [7:0]  q_d;

  FADDER_8bit u_adder (
    .x_i    (acc_q),
    .y_i    (m_q),
    .cin_i  (1'b0),
    .sum_o  (add_sum),
    .cout_o (add_cout)
  );

  // Conditional add then right shift of {C, ACC, Q}; the carry is consumed by the shift in the
  // same edge and a zero enters behind it, so C never needs to be held across edges.
  always_comb begin
    c_d       = 1'b0;
    acc_sum_d = acc_q;
    if (q_q[0]) begin
      c_d       = add_cout;
      acc_sum_d = add_sum;
    end
    acc_d = {c_d, acc_sum_d[7:1]};
    q_d   = {acc_sum_d[0], q_q[7:1]};
  end

  // Control FSM with datapath registers and registered handshake outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      m_q       <= 8'h00;
      q_q       <= 8'h00;
      acc_q     <= 8'h00;
      cnt_q     <= 3'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= 16'h0000;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            m_q     <= a_i;
            q_q     <= b_i;
            acc_q   <= 8'h00;
            cnt_q   <= 3'd0;
            busy_q  <= 1'b1;
            state_q <= StRun;
          end
        end
        StRun: begin
          acc_q <= acc_d;
          q_q   <= q_d;
          cnt_q <= cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            product_q <= {acc_d, q_d};
            done_q    <= 1'b1;
            state_q   <= StDone;
          end
        end
        StDone: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign product_o = product_q;

endmodule

// File: tb/tb_seq_mult_8bit.sv
// Scoreboard bench for seq_mult_8bit: the driver queues expected products, a negedge monitor
// checks each done pulse, its latency and width, and the busy window.
module tb_seq_mult_8bit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        busy;
  logic        done;
  logic [15:0] product;

  seq_mult_8bit dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .start_i   (start),
    .a_i       (a),
    .b_i       (b),
    .busy_o    (busy),
    .done_o    (done),
    .product_o (product)
  );

  int          checks = 0;
  int          passed = 0;
  int          ncyc = 0;
  int          accepts = 0;
  int          dones = 0;
  logic [15:0] exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) ncyc <= ncyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (time %0t)", name, act, exp, $time);
  endtask

  // Monitor: outputs sampled on the falling edge, away from the active edge.
  initial begin : monitor
    logic        prev_busy;
    logic        prev_done;
    int          start_cyc;
    logic [15:0] exp;
    prev_busy = 1'b0;
    prev_done = 1'b0;
    start_cyc = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_busy = 1'b0;
        prev_done = 1'b0;
      end else begin
        if (busy && !prev_busy) begin
          start_cyc = ncyc;
          accepts++;
        end
        if (done) begin
          dones++;
          chk("done_latency", ncyc - start_cyc, 8);
          chk("done_within_busy", int'(busy), 1);
          chk("done_width", int'(prev_done), 0);
          chk("expected_available", int'(exp_q.size() != 0), 1);
          if (exp_q.size() != 0) begin
            exp = exp_q.pop_front();
            chk("product", int'(product), int'(exp));
          end
        end
        if (!busy && prev_busy) chk("busy_length", ncyc - start_cyc, 9);
        prev_busy = busy;
        prev_done = done;
      end
    end
  end

  // Wait on falling edges until busy equals val; an expired bound counts as a failure.
  task automatic wait_busy(input logic val, input int limit);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy !== val && n < limit);
    if (busy !== val) chk("busy_wait_timeout", int'(busy), int'(val));
  endtask

  task automatic do_mult(input logic [7:0] av, input logic [7:0] bv, input logic [15:0] exp);
    @(negedge clk);
    a     = av;
    b     = bv;
    start = 1'b1;
    exp_q.push_back(exp);
    wait_busy(1'b1, 5);
    start = 1'b0;
    a     = ~av;
    b     = bv ^ 8'h5a;
    wait_busy(1'b0, 20);
  endtask

  initial begin : driver
    int t0;
    int t1;
    logic [7:0] ra;
    logic [7:0] rb;
    rst   = 1'b1;
    start = 1'b0;
    a     = 8'h00;
    b     = 8'h00;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_product", int'(product), 0);

    // Idle with start low: nothing moves.
    a = 8'hff;
    b = 8'hff;
    repeat (20) @(negedge clk);
    chk("idle_busy", int'(busy), 0);
    chk("idle_done", int'(done), 0);
    chk("idle_product", int'(product), 0);
    chk("idle_dones", dones, 0);

    // 13 * 11, then product must hold after done falls.
    do_mult(8'd13, 8'd11, 16'h008f);
    repeat (3) @(negedge clk);
    chk("product_held", int'(product), 16'h008f);

    // Boundary operands.
    do_mult(8'hff, 8'hff, 16'hfe01);
    do_mult(8'h80, 8'h02, 16'h0100);
    do_mult(8'h00, 8'hab, 16'h0000);
    do_mult(8'hab, 8'h01, 16'h00ab);

    // Start held high; operands change mid-run; second accept 10 cycles after the first.
    @(negedge clk);
    a     = 8'd3;
    b     = 8'd5;
    start = 1'b1;
    exp_q.push_back(16'h000f);
    exp_q.push_back(16'h003f);
    wait_busy(1'b1, 5);
    t0 = ncyc;
    repeat (2) @(negedge clk);
    a = 8'd7;
    b = 8'd9;
    wait_busy(1'b0, 20);
    wait_busy(1'b1, 5);
    t1 = ncyc;
    chk("reissue_interval", t1 - t0, 10);
    start = 1'b0;
    wait_busy(1'b0, 20);
    chk("held_start_product", int'(product), 16'h003f);

    // Asynchronous reset mid-run abandons the operation.
    @(negedge clk);
    a     = 8'd200;
    b     = 8'd100;
    start = 1'b1;
    wait_busy(1'b1, 5);
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_product", int'(product), 0);
    @(posedge clk);
    #2 rst = 1'b0;
    repeat (12) @(negedge clk);
    chk("abort_no_done", int'(product), 0);
    do_mult(8'd6, 8'd7, 16'h002a);

    // Random operands with random idle gaps.
    for (int i = 0; i < 500; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      repeat ($urandom_range(0, 4)) @(negedge clk);
      do_mult(ra, rb, 16'(ra) * 16'(rb));
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    // The aborted 200*100 was accepted but must never complete.
    chk("one_done_per_start", dones, accepts - 1);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
